// File: rtl/gray_tick_counter.sv
// N-bit Gray-code tick counter with IDLE/RUN/PAUSE run control, binary mirror
// and terminal-count pulse. Define GRAY_CHECK_EN to build the sticky Gray-adjacency checker.
module gray_tick_counter #(
  parameter int N    = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         up,
  output logic [N-1:0] gray,
  output logic [N-1:0] bin,
  output logic         running,
  output logic         tc,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [N-1:0] MAX_VAL = {N{1'b1}};

  state_t       state, state_nxt;
  logic         advance;
  logic         at_limit;
  logic [N-1:0] bin_step;
  logic [N-1:0] term_val;
  logic         tc_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Priority: clear > stop > start. A simultaneous start/stop never enters RUN.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (clear)
      state_nxt = IDLE;
    else if (stop) begin
      if (state == RUN) state_nxt = PAUSE;
    end else if (start && state != RUN)
      state_nxt = RUN;
  end

  // Only a tick seen while already in RUN counts; the entering cycle is ignored.
  assign advance = (state == RUN) && tick && !stop && !clear;

  always_comb begin
    bin_step = bin;
    at_limit = up ? (bin == MAX_VAL) : (bin == '0);
    term_val = up ? MAX_VAL : '0;
    if (!at_limit || WRAP)
      bin_step = up ? bin + 1'b1 : bin - 1'b1;
    // A value held at saturation is not a fresh arrival at the terminal count.
    tc_nxt = advance && (bin_step != bin) && (bin_step == term_val);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin     <= '0;
      gray    <= '0;
      tc      <= 1'b0;
      running <= 1'b0;
    end else if (clear) begin
      bin     <= '0;
      gray    <= '0;
      tc      <= 1'b0;
      running <= 1'b0;
    end else begin
      tc      <= tc_nxt;
      running <= (state_nxt == RUN);
      if (advance) begin
        bin  <= bin_step;
        gray <= bin_step ^ (bin_step >> 1);
      end
    end
  end

`ifdef GRAY_CHECK_EN
  logic [N-1:0] gray_prev;
  logic [N-1:0] gray_diff;
  logic         clr_q;
  logic         err_q;

  assign gray_diff = gray ^ gray_prev;

  // The jump to zero right after a clear is legitimate, so that cycle is skipped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gray_prev <= '0;
      clr_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      gray_prev <= gray;
      clr_q     <= clear;
      if (clear)
        err_q <= 1'b0;
      else if (!clr_q && ((gray_diff & (gray_diff - 1'b1)) != '0))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_tick_counter.sv
// Self-checking bench for gray_tick_counter: a wrapping and a saturating instance
// share stimulus; expectations are queued per step and popped after each edge.
module tb_gray_tick_counter;

  typedef struct packed {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
    logic       running;
    logic       err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, up = 1'b1;
  logic [3:0] w_gray, w_bin, s_gray, s_bin;
  logic       w_running, w_tc, w_err, s_running, s_tc, s_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];
  obs_t e, o;

  always #5 clk = ~clk;

  gray_tick_counter #(.N(4), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear), .up(up),
    .gray(w_gray), .bin(w_bin), .running(w_running), .tc(w_tc), .err(w_err));

  gray_tick_counter #(.N(4), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear), .up(up),
    .gray(s_gray), .bin(s_bin), .running(s_running), .tc(s_tc), .err(s_err));

  function automatic obs_t obs_w();
    return '{w_bin, w_gray, w_tc, w_running, w_err};
  endfunction

  function automatic obs_t obs_s();
    return '{s_bin, s_gray, s_tc, s_running, s_err};
  endfunction

  function automatic logic [3:0] gc(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic obs_t mk(input logic [3:0] b, input logic [3:0] g, input logic t, input logic r);
    return '{b, g, t, r, 1'b0};
  endfunction

  // Drive inputs on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic t, input logic st, input logic sp, input logic cl, input logic u);
    @(negedge clk);
    tick = t; start = st; stop = sp; clear = cl; up = u;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0));
    e = exp_q.pop_front(); o = obs_w(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_wrap got %h want %h", o, e); end
    e = exp_q.pop_front(); o = obs_s(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_sat got %h want %h", o, e); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [3:0] gtab [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1);
    exp_q.push_back(mk(4'h0, 4'h0, 1'b0, 1'b1));
    e = exp_q.pop_front(); o = obs_w(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL wrap_up_start got %h want %h", o, e); end
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(mk(4'(i), gtab[i-1], i == 15, 1'b1));
      step(1, 0, 0, 0, 1);
      e = exp_q.pop_front(); o = obs_w(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_up tick%0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_wrap_down();
    logic [3:0] b  [5] = '{4'h1, 4'h2, 4'h1, 4'h0, 4'h0};
    logic       u  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       t  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       tx [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(b[i], gc(b[i]), tx[i], 1'b1));
      step(t[i], 0, 0, 0, u[i]);
      e = exp_q.pop_front(); o = obs_w(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_down step%0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_saturate();
    int         tc_cnt = 0;
    logic [3:0] b;
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1);
    for (int i = 1; i <= 18; i++) begin
      b = (i > 15) ? 4'hF : 4'(i);
      exp_q.push_back(mk(b, gc(b), i == 15, 1'b1));
      step(1, 0, 0, 0, 1);
      e = exp_q.pop_front(); o = obs_s(); n_tests++;
      if (s_tc) tc_cnt++;
      if (o !== e) begin n_fail++; $display("FAIL sat_up tick%0d got %h want %h", i, o, e); end
    end
    n_tests++;
    if (tc_cnt !== 1) begin n_fail++; $display("FAIL sat_tc_count got %0d want 1", tc_cnt); end
    if (s_gray !== 4'h8) begin n_fail++; $display("FAIL sat_gray got %h want 8", s_gray); end
    n_tests++;
    // Down from zero: saturating instance holds without tc, wrapping one goes to F without tc.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    exp_q.push_back(mk(4'h0, 4'h0, 1'b0, 1'b1));
    exp_q.push_back(mk(4'hF, 4'h8, 1'b0, 1'b1));
    step(1, 0, 0, 0, 0);
    e = exp_q.pop_front(); o = obs_s(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL sat_down_hold got %h want %h", o, e); end
    e = exp_q.pop_front(); o = obs_w(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL wrap_down_zero got %h want %h", o, e); end
  endtask

  task automatic test_stop_tick();
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0, 1);
    // stop+tick, three ignored ticks, start+tick (ignored), tick, start+stop
    begin
      logic t  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic st [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic sp [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [3:0] b [7] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h6, 4'h6};
      logic r  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
        exp_q.push_back(mk(b[i], gc(b[i]), 1'b0, r[i]));
        step(t[i], st[i], sp[i], 0, 1);
        e = exp_q.pop_front(); o = obs_w(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL stop_tick step%0d got %h want %h", i, o, e); end
      end
    end
  endtask

  task automatic test_clear();
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1);
    repeat (9) step(1, 0, 0, 0, 1);
    exp_q.push_back(mk(4'h9, 4'hD, 1'b0, 1'b1));
    e = exp_q.pop_front(); o = obs_w(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL clear_pre got %h want %h", o, e); end
    exp_q.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0));
    step(1, 0, 0, 1, 1);
    e = exp_q.pop_front(); o = obs_w(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL clear_with_tick got %h want %h", o, e); end
    step(1, 0, 0, 0, 1);
    e = exp_q.pop_front(); o = obs_w(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL clear_idle_tick got %h want %h", o, e); end
  endtask

  task automatic test_async_reset();
    step(0, 1, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0, 1);
    #2 rst = 1'b0;
    #1;
    exp_q.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0));
    e = exp_q.pop_front(); o = obs_w(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL async_rst_immediate got %h want %h", o, e); end
    tick = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0));
    e = exp_q.pop_front(); o = obs_w(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL async_rst_held got %h want %h", o, e); end
    @(negedge clk);
    rst = 1'b1; start = 1'b0; tick = 1'b0;
    begin
      logic t  [3] = '{1'b1, 1'b0, 1'b1};
      logic st [3] = '{1'b0, 1'b1, 1'b0};
      logic [3:0] b [3] = '{4'h0, 4'h0, 4'h1};
      logic r  [3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(mk(b[i], gc(b[i]), 1'b0, r[i]));
        step(t[i], st[i], 0, 0, 1);
        e = exp_q.pop_front(); o = obs_w(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL async_rst_release step%0d got %h want %h", i, o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_stop_tick();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
